// File: rtl/reflet_boot_pkg.sv
// rtl/reflet_boot_pkg.sv - shared types, constants and helpers for the Reflet UART boot loader
package reflet_boot_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM,
        RUN,
        ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Integer-truncated number of system clocks per UART bit
    function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/reflet_uart_boot_loader_if.sv
// rtl/reflet_uart_boot_loader_if.sv - instruction RAM write port driven by the boot loader
interface reflet_uart_boot_loader_if #(
    parameter int addr_size = 7
);
    logic [addr_size-1:0] mem_addr;
    logic [7:0]           mem_data;
    logic                 mem_write_en;

    modport master (output mem_addr, output mem_data, output mem_write_en);
    modport slave  (input  mem_addr, input  mem_data, input  mem_write_en);
endinterface

// File: rtl/reflet_boot_uart_rx.sv
// rtl/reflet_boot_uart_rx.sv - 8N1 UART receiver with synchroniser, glitch-rejecting start bit
module reflet_boot_uart_rx
    import reflet_boot_pkg::*;
#(
    parameter int cpb = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(cpb + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(cpb / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(cpb - 1);

    logic            meta_q, sync_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Synchroniser chain, edge history and receiver state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: start bit checked at half period, data and stop bits at mid-bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again by mid-start was only a glitch
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/reflet_uart_boot_loader.sv
// rtl/reflet_uart_boot_loader.sv - loads a checksummed program image over UART into instruction RAM
module reflet_uart_boot_loader
    import reflet_boot_pkg::*;
#(
    parameter int clk_freq       = 1000000,
    parameter int baud_rate      = 9600,
    parameter int addr_size      = 7,
    parameter int mem_size       = 128,
    parameter int timeout_cycles = clk_freq / 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_i,
    input  logic                        skip_boot_i,
    reflet_uart_boot_loader_if.master   mem,
    output logic                        cpu_run_o,
    output logic                        busy_o,
    output logic                        error_o
);

    localparam int CPB = cycles_per_bit(clk_freq, baud_rate);
    localparam int TW  = $clog2(timeout_cycles + 1);

    logic [7:0]           rx_byte;
    logic                 rx_valid, rx_ferr;

    boot_state_t          state_q, state_d;
    logic [addr_size-1:0] idx_q, idx_d;
    logic [addr_size-1:0] last_q, last_d;
    logic [7:0]           sum_q, sum_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 we_q, we_d;
    logic                 error_q, error_d;
    logic [TW-1:0]        idle_q, idle_d;
    logic                 busy_st, byte_evt, timeout;

    reflet_boot_uart_rx #(.cpb(CPB)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    // Loader state, checksum, write port and idle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_SYNC;
            idx_q   <= '0;
            last_q  <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            error_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            error_q <= error_d;
            idle_q  <= idle_d;
        end
    end

    assign busy_st  = (state_q == GET_LEN) || (state_q == GET_DATA) || (state_q == GET_SUM);
    assign byte_evt = rx_valid || rx_ferr;
    // A byte landing on the expiry cycle wins over the timeout
    assign timeout  = busy_st && !byte_evt && (idle_q == TW'(timeout_cycles - 1));

    // Next-state logic: sync, length, data, checksum, then run or fail
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        error_d = error_q;
        idle_d  = '0;
        if (busy_st) idle_d = byte_evt ? TW'(1) : idle_q + TW'(1);
        unique case (state_q)
            WAIT_SYNC: begin
                if (skip_boot_i) begin
                    state_d = RUN;
                end else if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = GET_LEN;
                    error_d = 1'b0;
                end
            end
            GET_LEN: begin
                if (rx_ferr || timeout) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    if (rx_byte == 8'd0 || 32'(rx_byte) > mem_size) begin
                        state_d = ERROR;
                    end else begin
                        // Keep len-1 so the last index fits the address width
                        last_d  = addr_size'(rx_byte - 8'd1);
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (rx_ferr || timeout) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    addr_d = idx_q;
                    data_d = rx_byte;
                    we_d   = 1'b1;
                    sum_d  = sum_q + rx_byte;
                    idx_d  = idx_q + addr_size'(1);
                    if (idx_q == last_q) state_d = GET_SUM;
                end
            end
            GET_SUM: begin
                if (rx_ferr || timeout) begin
                    state_d = ERROR;
                end else if (rx_valid) begin
                    state_d = (rx_byte == sum_q) ? RUN : ERROR;
                end
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = WAIT_SYNC;
            default: state_d = WAIT_SYNC;
        endcase
        if (state_d == ERROR) error_d = 1'b1;
    end

    assign mem.mem_addr     = addr_q;
    assign mem.mem_data     = data_q;
    assign mem.mem_write_en = we_q;
    assign cpu_run_o        = (state_q == RUN);
    assign busy_o           = busy_st;
    assign error_o          = error_q;

endmodule

// File: tb/tb_reflet_uart_boot_loader.sv
// tb/tb_reflet_uart_boot_loader.sv - self-checking bench for the Reflet UART boot loader
module tb_reflet_uart_boot_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic skip_boot = 1'b0;
    logic cpu_run, busy, error;

    reflet_uart_boot_loader_if #(.addr_size(7)) memif ();

    reflet_uart_boot_loader #(
        .clk_freq       (1000000),
        .baud_rate      (100000),
        .addr_size      (7),
        .mem_size       (128),
        .timeout_cycles (500)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx),
        .skip_boot_i (skip_boot),
        .mem         (memif),
        .cpu_run_o   (cpu_run),
        .busy_o      (busy),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    int cyc = 0;
    int last_valid_cyc = -1;
    int nvalid = 0;
    int run_cyc = -1;
    int err_cyc = -1;
    int wide = 0;
    logic busy_at_err = 1'b0;
    logic prev_we = 1'b0, prev_run = 1'b0, prev_err = 1'b0;
    int waddr[$];
    logic [7:0] wdata[$];

    typedef struct {
        logic [47:0] bytes;
        int          n;
        int          dpos;
        int          nwr;
        logic        run;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs[8];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (dut.u_rx.byte_valid_o) begin
            last_valid_cyc = cyc;
            nvalid = nvalid + 1;
        end
        if (memif.mem_write_en) begin
            waddr.push_back(int'(memif.mem_addr));
            wdata.push_back(memif.mem_data);
            if (prev_we) wide = wide + 1;
        end
        if (cpu_run && !prev_run) run_cyc = cyc;
        if (error && !prev_err) begin
            err_cyc = cyc;
            busy_at_err = busy;
        end
        prev_we  = memif.mem_write_en;
        prev_run = cpu_run;
        prev_err = error;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        waddr.delete();
        wdata.delete();
        wide = 0;
        run_cyc = -1;
        err_cyc = -1;
        last_valid_cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        skip_boot = 1'b0;
        rx = 1'b1;
        tick(3);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = stop;
        tick(10);
        rx = 1'b1;
        tick(10);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_addr"}, 32'(memif.mem_addr), 32'h0);
        chk({tag, "_data"}, 32'(memif.mem_data), 32'h0);
        chk({tag, "_we"}, 32'(memif.mem_write_en), 32'h0);
        chk({tag, "_run"}, 32'(cpu_run), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(error), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int n0;

        vecs[0] = '{48'h5A0311223366, 6, 2, 3, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{48'h5A0210200000, 5, 2, 2, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{48'h5A01ABAB0000, 4, 2, 1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{48'h5A0000000000, 2, 2, 0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{48'h5A8100000000, 2, 2, 0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{48'h335A01070700, 5, 3, 1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{48'h5A02FF020100, 5, 2, 2, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{48'h5A8000000000, 2, 2, 0, 1'b0, 1'b0, 1'b1};

        do_reset();
        @(negedge clk);
        check_zero_outputs("reset");

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) begin
                b = vecs[v].bytes[47-8*i -: 8];
                send_frame(b, 1'b1);
            end
            tick(5);
            @(negedge clk);
            chk($sformatf("v%0d_run", v), 32'(cpu_run), 32'(vecs[v].run));
            chk($sformatf("v%0d_err", v), 32'(error), 32'(vecs[v].err));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            chk($sformatf("v%0d_nwr", v), 32'(waddr.size()), 32'(vecs[v].nwr));
            chk($sformatf("v%0d_wide", v), 32'(wide), 32'h0);
            for (int k = 0; k < vecs[v].nwr; k++) begin
                if (k < waddr.size()) begin
                    b = vecs[v].bytes[47-8*(vecs[v].dpos+k) -: 8];
                    chk($sformatf("v%0d_wa%0d", v, k), 32'(waddr[k]), 32'(k));
                    chk($sformatf("v%0d_wd%0d", v, k), 32'(wdata[k]), 32'(b));
                end
            end
            if (vecs[v].run)
                chk($sformatf("v%0d_run_lat", v), 32'(run_cyc - last_valid_cyc), 32'd1);
        end

        // Bad checksum, then a fresh sync clears the sticky error and a good image runs
        do_reset();
        send_frame(8'h5A, 1'b1); send_frame(8'h02, 1'b1); send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1); send_frame(8'h00, 1'b1);
        @(negedge clk);
        chk("rec_err_set", 32'(error), 32'h1);
        chk("rec_run0", 32'(cpu_run), 32'h0);
        send_frame(8'h5A, 1'b1);
        @(negedge clk);
        chk("rec_err_clr", 32'(error), 32'h0);
        chk("rec_busy", 32'(busy), 32'h1);
        send_frame(8'h01, 1'b1); send_frame(8'hAB, 1'b1); send_frame(8'hAB, 1'b1);
        @(negedge clk);
        chk("rec_run", 32'(cpu_run), 32'h1);
        chk("rec_nwr", 32'(waddr.size()), 32'd3);
        if (waddr.size() == 3) begin
            chk("rec_wa", 32'(waddr[2]), 32'h0);
            chk("rec_wd", 32'(wdata[2]), 32'hAB);
        end

        // Idle timeout while waiting for data
        do_reset();
        send_frame(8'h5A, 1'b1); send_frame(8'h04, 1'b1);
        send_frame(8'h01, 1'b1); send_frame(8'h02, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            if (err_cyc >= 0) break;
            @(negedge clk);
        end
        chk("to_latency", 32'(err_cyc - last_valid_cyc), 32'd500);
        chk("to_busy", 32'(busy_at_err), 32'h0);
        chk("to_nwr", 32'(waddr.size()), 32'd2);

        // Frame error during load, then a short glitch in WAIT_SYNC
        do_reset();
        send_frame(8'h5A, 1'b1); send_frame(8'h01, 1'b1);
        send_frame(8'h3C, 1'b0);
        @(negedge clk);
        chk("fe_err", 32'(error), 32'h1);
        chk("fe_busy", 32'(busy), 32'h0);
        chk("fe_nwr", 32'(waddr.size()), 32'd0);
        n0 = nvalid;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        chk("glitch_nvalid", 32'(nvalid - n0), 32'd0);
        chk("glitch_err", 32'(error), 32'h1);
        send_frame(8'h5A, 1'b1); send_frame(8'h01, 1'b1);
        send_frame(8'h5C, 1'b1); send_frame(8'h5C, 1'b1);
        @(negedge clk);
        chk("fe_recover_run", 32'(cpu_run), 32'h1);

        // skip_boot: one cycle in WAIT_SYNC, then RUN
        reset = 1'b1;
        skip_boot = 1'b1;
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("skip_run0", 32'(cpu_run), 32'h0);
        tick(1);
        @(negedge clk);
        chk("skip_run1", 32'(cpu_run), 32'h1);
        chk("skip_busy", 32'(busy), 32'h0);

        // Reset in the middle of GET_DATA
        do_reset();
        send_frame(8'h5A, 1'b1); send_frame(8'h03, 1'b1);
        send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_addr", 32'(memif.mem_addr), 32'h1);
        chk("mid_data", 32'(memif.mem_data), 32'h22);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        check_zero_outputs("midrst");
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
